// File: rtl/mem_access_if.sv
// mem_access_if: request/response bundle between the datapath controller and the memory port
interface mem_access_if #(
  parameter int WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  localparam int NB = WIDTH / 8;
  logic start;
  logic is_write;
  logic is_byte;
  logic [ADDR_WIDTH-1:0] address;
  logic [WIDTH-1:0] wdata;
  logic busy;
  logic done;
  logic err;
  logic [WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic mem_read;
  logic mem_write;
  logic [NB-1:0] mem_byte_enable;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic mem_resp;
  modport master (
    output start, is_write, is_byte, address, wdata, mem_rdata, mem_resp,
    input busy, done, err, rdata, mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
  );
  modport slave (
    input start, is_write, is_byte, address, wdata, mem_rdata, mem_resp,
    output busy, done, err, rdata, mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR memory access unit with word/byte lanes, handshake and response timeout
module mem_access_unit #(
  parameter int WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  mem_access_if.slave bus
);
  localparam int NB = WIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_we, r_byte, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [NB-1:0] r_be;
  logic [WIDTH-1:0] r_wdata, r_rdata;
  logic w_accept, w_timeout;
  logic [LW-1:0] w_lane;
  logic [7:0] w_rbyte;
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_accept = r_state == IDLE && bus.start;
    w_timeout = TIMEOUT != 0 && r_cnt == CW'(TIMEOUT - 1);
    w_next = r_state == IDLE ? (bus.start ? ACCESS : IDLE) :
             r_state == ACCESS ? (bus.mem_resp || w_timeout ? DONE : ACCESS) : IDLE;
    w_lane = r_addr[LW-1:0];
    w_rbyte = bus.mem_rdata[8*w_lane +: 8];
    bus.busy = r_state == ACCESS;
    bus.done = r_state == DONE;
    bus.mem_read = r_state == ACCESS && !r_we;
    bus.mem_write = r_state == ACCESS && r_we;
    bus.err = r_err;
    bus.rdata = r_rdata;
    bus.mem_address = r_addr;
    bus.mem_byte_enable = r_be;
    bus.mem_wdata = r_wdata;
  end
  // A response arriving in the last allowed cycle wins over the timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_we <= 1'b0;
      r_byte <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_be <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_cnt <= r_state == ACCESS ? r_cnt + CW'(1) : '0;
      if (w_accept) begin
        r_we <= bus.is_write;
        r_byte <= bus.is_byte;
        r_err <= 1'b0;
        r_addr <= bus.is_byte ? bus.address : {bus.address[ADDR_WIDTH-1:LW], LW'(0)};
        r_be <= bus.is_byte ? NB'(1) << bus.address[LW-1:0] : '1;
        r_wdata <= bus.is_byte ? {NB{bus.wdata[7:0]}} : bus.wdata;
      end
      if (r_state == ACCESS && bus.mem_resp && !r_we)
        r_rdata <= r_byte ? WIDTH'(w_rbyte) : bus.mem_rdata;
      else if (r_state == ACCESS && !bus.mem_resp && w_timeout)
        r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a transaction-level model
module tb_mem_access_unit;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] ref_rdata = '0;
  logic [31:0] ref_rdata32 = '0;
  always #5 clk = ~clk;
  mem_access_if #(.WIDTH(16), .ADDR_WIDTH(16)) a ();
  mem_access_if #(.WIDTH(32), .ADDR_WIDTH(16)) b ();
  mem_access_unit #(.WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(TO)) u_a (.clk(clk), .reset(reset), .bus(a));
  mem_access_unit #(.WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(0)) u_b (.clk(clk), .reset(reset), .bus(b));

  task automatic test_reset();
    {a.start, a.is_write, a.is_byte, a.address, a.wdata, a.mem_rdata, a.mem_resp} = '0;
    {b.start, b.is_write, b.is_byte, b.address, b.wdata, b.mem_rdata, b.mem_resp} = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a.busy, a.done, a.err, a.rdata, a.mem_address, a.mem_read, a.mem_write, a.mem_byte_enable, a.mem_wdata} !== '0)
      begin failures++; $display("FAIL reset16 got=%h exp=0", {a.busy, a.done, a.err, a.rdata, a.mem_address, a.mem_read, a.mem_write, a.mem_byte_enable, a.mem_wdata}); end
    checks++;
    if ({b.busy, b.done, b.err, b.rdata, b.mem_address, b.mem_read, b.mem_write, b.mem_byte_enable, b.mem_wdata} !== '0)
      begin failures++; $display("FAIL reset32 got=%h exp=0", {b.busy, b.done, b.err, b.rdata, b.mem_address, b.mem_read, b.mem_write, b.mem_byte_enable, b.mem_wdata}); end
    reset = 1'b0;
  endtask

  // Entered and left at a negedge in IDLE so consecutive calls run back to back
  task automatic access(input bit w, input bit by, input logic [15:0] addr, input logic [15:0] wd, input int lat, input logic [15:0] md);
    logic [15:0] ea, ew;
    logic [1:0] ebe;
    logic [37:0] got_r, exp_r;
    logic [20:0] got_d, exp_d;
    logic [18:0] got_i, exp_i;
    bit resp;
    int last;
    ea = by ? addr : addr & 16'hFFFE;
    ebe = by ? 2'(1 << addr[0]) : 2'b11;
    ew = by ? 16'(wd[7:0]) * 16'h0101 : wd;
    resp = lat < TO;
    last = resp ? lat : TO - 1;
    a.start = 1'b1; a.is_write = w; a.is_byte = by; a.address = addr; a.wdata = wd;
    @(negedge clk);
    a.start = 1'b0; a.address = 16'($urandom); a.wdata = 16'($urandom); a.is_byte = 1'($urandom);
    for (int c = 0; c <= last; c++) begin
      got_r = {a.busy, a.done, a.mem_read, a.mem_write, a.mem_address, a.mem_byte_enable, a.mem_wdata};
      exp_r = {1'b1, 1'b0, !w, w, ea, ebe, ew};
      checks++;
      if (got_r !== exp_r) begin failures++; $display("FAIL access_req c=%0d got=%h exp=%h", c, got_r, exp_r); end
      a.mem_resp = c == lat;
      a.mem_rdata = c == lat ? md : 16'($urandom);
      @(negedge clk);
      a.mem_resp = 1'b0;
    end
    if (resp && !w) ref_rdata = by ? 16'((md >> (8 * addr[0])) & 16'h00FF) : md;
    got_d = {a.busy, a.done, a.err, a.mem_read, a.mem_write, a.rdata};
    exp_d = {1'b0, 1'b1, !resp, 1'b0, 1'b0, ref_rdata};
    checks++;
    if (got_d !== exp_d) begin failures++; $display("FAIL access_done got=%h exp=%h", got_d, exp_d); end
    a.mem_resp = 1'($urandom);
    a.mem_rdata = 16'($urandom);
    @(negedge clk);
    a.mem_resp = 1'b0;
    got_i = {a.busy, a.done, a.err, a.rdata};
    exp_i = {1'b0, 1'b0, !resp, ref_rdata};
    checks++;
    if (got_i !== exp_i) begin failures++; $display("FAIL access_idle got=%h exp=%h", got_i, exp_i); end
  endtask

  task automatic test_directed();
    access(1'b0, 1'b0, 16'h1235, 16'h0000, 3, 16'hBEEF);
    access(1'b1, 1'b1, 16'h0041, 16'h12AB, 2, 16'h0000);
    access(1'b0, 1'b1, 16'h0040, 16'h0000, 0, 16'h80F7);
    access(1'b0, 1'b1, 16'h0041, 16'h0000, 1, 16'h80F7);
    access(1'b0, 1'b0, 16'h2000, 16'h0000, 10, 16'h5555);
    access(1'b1, 1'b0, 16'h3003, 16'hCAFE, 0, 16'h0000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      access(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 6)), 16'($urandom));
  endtask

  task automatic test_ignore();
    logic [34:0] got, exp;
    a.start = 1'b1; a.is_write = 1'b0; a.is_byte = 1'b0; a.address = 16'h0300;
    @(negedge clk);
    a.start = 1'b1; a.is_write = 1'b1; a.address = 16'h0501;
    @(negedge clk);
    a.start = 1'b0;
    checks++;
    if ({a.busy, a.mem_read, a.mem_write, a.mem_address} !== {1'b1, 1'b1, 1'b0, 16'h0300})
      begin failures++; $display("FAIL ignore_access got=%h exp=%h", {a.busy, a.mem_read, a.mem_write, a.mem_address}, {1'b1, 1'b1, 1'b0, 16'h0300}); end
    a.mem_resp = 1'b1; a.mem_rdata = 16'h1111;
    @(negedge clk);
    a.mem_resp = 1'b0; a.start = 1'b1; a.address = 16'h0700;
    ref_rdata = 16'h1111;
    checks++;
    if ({a.done, a.rdata} !== {1'b1, ref_rdata})
      begin failures++; $display("FAIL ignore_done got=%h exp=%h", {a.done, a.rdata}, {1'b1, ref_rdata}); end
    @(negedge clk);
    a.start = 1'b0;
    a.mem_resp = 1'b1; a.mem_rdata = 16'h2222;
    for (int c = 0; c < 2; c++) begin
      got = {a.busy, a.done, a.mem_read, a.mem_write, a.rdata, 15'd0};
      exp = {4'b0000, ref_rdata, 15'd0};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL ignore_idle c=%0d got=%h exp=%h", c, got, exp); end
      @(negedge clk);
      a.mem_resp = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    a.start = 1'b1; a.is_write = 1'b0; a.is_byte = 1'b0; a.address = 16'h0200;
    @(negedge clk);
    a.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_rdata = '0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({a.busy, a.done, a.mem_read, a.mem_write, a.rdata} !== {4'b0000, ref_rdata})
        begin failures++; $display("FAIL reset_mid c=%0d got=%h exp=%h", c, {a.busy, a.done, a.mem_read, a.mem_write, a.rdata}, {4'b0000, ref_rdata}); end
      @(negedge clk);
    end
  endtask

  task automatic wide_load(input bit by, input logic [15:0] addr, input int lat, input logic [31:0] md);
    logic [3:0] ebe;
    logic [15:0] ea;
    ebe = by ? 4'(1 << addr[1:0]) : 4'b1111;
    ea = by ? addr : addr & 16'hFFFC;
    b.start = 1'b1; b.is_write = 1'b0; b.is_byte = by; b.address = addr;
    @(negedge clk);
    b.start = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      checks++;
      if ({b.busy, b.err, b.mem_read, b.mem_address, b.mem_byte_enable} !== {1'b1, 1'b0, 1'b1, ea, ebe})
        begin failures++; $display("FAIL wide_req c=%0d got=%h exp=%h", c, {b.busy, b.err, b.mem_read, b.mem_address, b.mem_byte_enable}, {1'b1, 1'b0, 1'b1, ea, ebe}); end
      b.mem_resp = c == lat;
      b.mem_rdata = md;
      @(negedge clk);
      b.mem_resp = 1'b0;
    end
    ref_rdata32 = by ? (md >> (8 * addr[1:0])) & 32'hFF : md;
    checks++;
    if ({b.done, b.err, b.rdata} !== {1'b1, 1'b0, ref_rdata32})
      begin failures++; $display("FAIL wide_done got=%h exp=%h", {b.done, b.err, b.rdata}, {1'b1, 1'b0, ref_rdata32}); end
    @(negedge clk);
  endtask

  task automatic test_wide();
    wide_load(1'b1, 16'h0103, 0, 32'hA1B2C3D4);
    for (int i = 0; i < 8; i++)
      wide_load(1'b1, 16'($urandom), int'($urandom_range(0, 3)), $urandom);
    wide_load(1'b0, 16'h4006, 80, 32'h12345678);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_reset_mid();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
